// File: rtl/onewire_slave.sv
// onewire_slave: 1-wire bus slave with reset/presence handling, byte receive and CMD_READ-triggered byte transmit.
module onewire_slave #(
  parameter int T_RST = 40000,
  parameter int T_PDH = 3000,
  parameter int T_PDL = 12000,
  parameter int T_SMP = 1500,
  parameter int T_RDL = 3000,
  parameter logic [7:0] CMD_READ = 8'hBE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dq_in,
  output logic       dq_oe,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_done
);
  localparam int M1 = T_RST > T_PDL ? T_RST : T_PDL;
  localparam int M2 = T_PDH > T_SMP ? T_PDH : T_SMP;
  localparam int M3 = M2 > T_RDL ? M2 : T_RDL;
  localparam int MX = M1 > M3 ? M1 : M3;
  localparam int W = $clog2(MX + 1) > 16 ? $clog2(MX + 1) : 16;
  typedef enum logic [2:0] {IDLE, RST_SEEN, PRES_WAIT, PRES_LOW, RX, TX} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [W-1:0] low_cnt, tmr, tmr_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, txb, txb_n, rx_data_n;
  logic busy, busy_n, first, first_n, rx_valid_n, tx_done_n, dq_oe_n;
  logic fall, rise, rst_hit;
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;
  // fires on the cycle the low counter reaches T_RST, and keeps firing while the line stays low
  assign rst_hit = ~s2 & (low_cnt >= W'(T_RST - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b111;
      low_cnt <= '0;
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      sh <= '0;
      txb <= '0;
      busy <= 1'b0;
      first <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_done <= 1'b0;
      dq_oe <= 1'b0;
    end else begin
      {s1, s2, s3} <= {dq_in, s1, s2};
      low_cnt <= s2 ? '0 : (low_cnt == W'(T_RST) ? low_cnt : low_cnt + 1'b1);
      state <= state_n;
      tmr <= tmr_n;
      cnt <= cnt_n;
      sh <= sh_n;
      txb <= txb_n;
      busy <= busy_n;
      first <= first_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_done <= tx_done_n;
      dq_oe <= dq_oe_n;
    end
  end
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    cnt_n = cnt;
    sh_n = sh;
    txb_n = txb;
    busy_n = busy;
    first_n = first;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    tx_done_n = 1'b0;
    if (rst_hit) begin
      state_n = RST_SEEN;
      tmr_n = '0;
      cnt_n = '0;
      sh_n = '0;
      busy_n = 1'b0;
    end else begin
      case (state)
        RST_SEEN: if (rise) begin
          state_n = PRES_WAIT;
          tmr_n = '0;
        end
        PRES_WAIT: if (tmr == W'(T_PDH - 1)) begin
          state_n = PRES_LOW;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
        PRES_LOW: if (tmr == W'(T_PDL - 1)) begin
          state_n = RX;
          tmr_n = '0;
          cnt_n = '0;
          sh_n = '0;
          first_n = 1'b1;
          busy_n = 1'b0;
        end else tmr_n = tmr + 1'b1;
        RX: if (busy) begin
          if (tmr == W'(T_SMP - 1)) begin
            busy_n = 1'b0;
            sh_n[cnt] = s2;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              first_n = 1'b0;
              if (first && sh_n == CMD_READ) begin
                state_n = TX;
                txb_n = tx_data;
              end else begin
                rx_data_n = sh_n;
                rx_valid_n = 1'b1;
              end
            end
          end else tmr_n = tmr + 1'b1;
        end else if (fall) begin
          busy_n = 1'b1;
          tmr_n = '0;
        end
        TX: if (busy) begin
          if (tmr == W'(T_RDL - 1)) begin
            busy_n = 1'b0;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              tx_done_n = 1'b1;
              state_n = IDLE;
            end
          end else tmr_n = tmr + 1'b1;
        end else if (fall) begin
          busy_n = 1'b1;
          tmr_n = '0;
        end
        default: ;
      endcase
    end
    // a 1 bit occupies the slot timer too, so master edges inside it are ignored
    dq_oe_n = state_n == PRES_LOW || (state_n == TX && busy_n && !txb_n[cnt_n]);
  end
endmodule

// File: tb/tb_onewire_slave.sv
// tb_onewire_slave: directed bench driving a wired-AND 1-wire bus model against onewire_slave (scaled timings).
module tb_onewire_slave;
  localparam int T_RST = 400;
  localparam int T_PDH = 30;
  localparam int T_PDL = 120;
  localparam int T_SMP = 15;
  localparam int T_RDL = 30;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_low = 1'b0;
  logic dq_in, dq_oe, rx_valid, tx_done;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  int n_cmp = 0, n_bad = 0;
  int rx_cnt = 0, tx_cnt = 0, oe_rise = 0;
  logic oe_q = 1'b0;
  assign dq_in = ~(m_low | dq_oe);
  onewire_slave #(.T_RST(T_RST), .T_PDH(T_PDH), .T_PDL(T_PDL), .T_SMP(T_SMP), .T_RDL(T_RDL),
                  .CMD_READ(8'hBE)) dut (
    .clk(clk), .rst_n(rst_n), .dq_in(dq_in), .dq_oe(dq_oe), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (rx_valid) rx_cnt++;
    if (tx_done) tx_cnt++;
    if (dq_oe && !oe_q) oe_rise++;
    oe_q = dq_oe;
  end
  typedef struct {
    logic [7:0] wr;
    logic [7:0] exp_rx;
    int exp_pulses;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bus_reset(input int len);
    m_low = 1'b1;
    repeat (len) @(negedge clk);
    chk("oe_low_in_bus_reset", int'(dq_oe), 0);
    m_low = 1'b0;
  endtask
  task automatic expect_presence(input string nm);
    int n = 0;
    int w = 0;
    @(negedge clk);
    while (!dq_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_delay"}, n, T_PDH + 2);
    while (dq_oe && w < 1000) begin
      w++;
      @(negedge clk);
    end
    chk({nm, "_width"}, w, T_PDL);
    repeat (10) @(negedge clk);
  endtask
  task automatic write_bits(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      m_low = 1'b1;
      repeat (b[i] ? 3 : 40) @(negedge clk);
      m_low = 1'b0;
      repeat (b[i] ? 57 : 20) @(negedge clk);
    end
  endtask
  task automatic read_slot(output logic b, output logic seen);
    seen = 1'b0;
    b = 1'b1;
    m_low = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 2) m_low = 1'b0;
      if (k == 14) b = dq_in;
      seen |= dq_oe;
      @(negedge clk);
    end
  endtask
  initial begin
    int rx0, tx0, oe0, n;
    logic b, seen;
    logic [7:0] exp_tx;
    vt[0] = '{8'h3C, 8'h3C, 1};
    vt[1] = '{8'hA5, 8'hA5, 1};
    vt[2] = '{8'hBE, 8'hBE, 1};
    vt[3] = '{8'h00, 8'h00, 1};
    vt[4] = '{8'hFF, 8'hFF, 1};
    repeat (5) @(negedge clk);
    chk("rst_dq_oe", int'(dq_oe), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_presence_after_rst", oe_rise, 0);
    // exactly T_RST low cycles is the shortest pulse that counts as a bus reset
    bus_reset(T_RST);
    expect_presence("pres_min");
    foreach (vt[i]) begin
      rx0 = rx_cnt;
      write_bits(vt[i].wr, 8);
      repeat (5) @(negedge clk);
      chk($sformatf("rx_data_%0d", i), int'(rx_data), int'(vt[i].exp_rx));
      chk($sformatf("rx_pulses_%0d", i), rx_cnt - rx0, vt[i].exp_pulses);
    end
    bus_reset(T_RST + 100);
    expect_presence("pres_tx");
    tx_data = 8'hAA;
    exp_tx = 8'hAA;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    write_bits(8'hBE, 8);
    tx_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_slot(b, seen);
      chk($sformatf("tx_bit_%0d", i), int'(b), int'(exp_tx[i]));
      chk($sformatf("tx_oe_%0d", i), int'(seen), int'(!exp_tx[i]));
    end
    repeat (5) @(negedge clk);
    chk("tx_done_pulses", tx_cnt - tx0, 1);
    chk("no_rx_valid_for_cmd", rx_cnt - rx0, 0);
    chk("rx_data_kept", int'(rx_data), 8'hFF);
    oe0 = oe_rise;
    rx0 = rx_cnt;
    bus_reset(T_RST - 1);
    repeat (300) @(negedge clk);
    chk("short_low_no_presence", oe_rise - oe0, 0);
    write_bits(8'h3C, 8);
    chk("idle_ignores_slots", rx_cnt - rx0, 0);
    bus_reset(T_RST + 100);
    expect_presence("pres_rx_abort");
    rx0 = rx_cnt;
    write_bits(8'h3C, 3);
    bus_reset(T_RST + 100);
    chk("rx_abort_no_valid", rx_cnt - rx0, 0);
    expect_presence("pres_after_rx_abort");
    write_bits(8'h5A, 8);
    repeat (5) @(negedge clk);
    chk("rx_after_abort", int'(rx_data), 8'h5A);
    chk("rx_after_abort_pulse", rx_cnt - rx0, 1);
    bus_reset(T_RST + 100);
    expect_presence("pres_tx_abort");
    tx_data = 8'hAA;
    write_bits(8'hBE, 8);
    tx0 = tx_cnt;
    rx0 = rx_cnt;
    for (int i = 0; i < 3; i++) read_slot(b, seen);
    bus_reset(T_RST + 100);
    chk("tx_abort_no_done", tx_cnt - tx0, 0);
    chk("tx_abort_no_valid", rx_cnt - rx0, 0);
    expect_presence("pres_after_tx_abort");
    bus_reset(T_RST + 100);
    n = 0;
    while (!dq_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("pres_before_rst_seen", int'(dq_oe), 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dq_oe", int'(dq_oe), 0);
    chk("async_rst_rx_data", int'(rx_data), 0);
    chk("async_rst_rx_valid", int'(rx_valid), 0);
    chk("async_rst_tx_done", int'(tx_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    oe0 = oe_rise;
    repeat (400) @(negedge clk);
    chk("no_presence_after_mid_rst", oe_rise - oe0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/onewire_slave.md
ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 SHALL have parameter T_RST, default 40000, meaning minimum bus-low cycles recognised as a master reset pulse.
REQ-002 SHALL have parameter T_PDH, default 3000, meaning cycles from bus release to presence start.
REQ-003 SHALL have parameter T_PDL, default 12000, meaning presence pulse length in cycles.
REQ-004 SHALL have parameter T_SMP, default 1500, meaning cycles from slot falling edge to write-bit sample.
REQ-005 SHALL have parameter T_RDL, default 3000, meaning cycles the slave holds the bus low for a transmitted 0.
REQ-006 SHALL have parameter CMD_READ, default 8'hBE, meaning the command byte that selects transmit mode.
REQ-007 clk  input  1  system clock; one clock only; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 dq_in  input  1  sampled level of the open-drain 1-wire line; idle high via pullup.
REQ-010 dq_oe  output  1  1 = pull line low; 0 = release to high-Z.
REQ-011 tx_data  input  8  byte returned to the master after CMD_READ.
REQ-012 rx_data  output  8  last byte received from the master, LSB first.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 tx_done  output  1  one-cycle pulse after the 8th transmitted bit slot.

Function
REQ-015 SHALL pass dq_in through a 2-flop synchroniser; all timing is measured from the synchronised signal (2-cycle input latency).
REQ-016 SHALL detect slot start as a synchronised 1->0 transition.
REQ-017 SHALL keep a low-time counter that increments every cycle the synchronised line is low and clears when it is high, saturating at T_RST.
REQ-018 SHALL, in any state, enter RST_SEEN when the low counter reaches T_RST, aborting any byte in progress with no rx_valid or tx_done pulse and with dq_oe=0.
REQ-019 States: IDLE, RST_SEEN, PRES_WAIT, PRES_LOW, RX, TX.
REQ-020 IDLE: ignore slots; leave only via REQ-018.
REQ-021 RST_SEEN -> PRES_WAIT on synchronised rising edge.
REQ-022 PRES_WAIT: after T_PDH cycles, assert dq_oe and enter PRES_LOW.
REQ-023 PRES_LOW: hold dq_oe=1 exactly T_PDL cycles, then release and enter RX with bit count 0 and first_byte=1.
REQ-024 RX: on each slot start, wait T_SMP cycles and shift the synchronised level into bit [count] (LSB first); count wraps 7->0.
REQ-025 RX: on the 8th bit, update rx_data and pulse rx_valid the following cycle.
REQ-026 RX: if first_byte and the byte equals CMD_READ, latch tx_data in the same cycle and enter TX; otherwise stay in RX; clear first_byte in either case.
REQ-027 Non-command bytes after the first SHALL each produce rx_valid; CMD_READ appearing later is treated as data.
REQ-028 TX: on each slot start, for a 0 bit assert dq_oe on the next cycle for T_RDL cycles; for a 1 bit keep dq_oe=0; bits sent LSB first from the latched copy.
REQ-029 TX: after the 8th slot completes (drive released or T_RDL elapsed), pulse tx_done and enter IDLE.
REQ-030 Slot starts arriving while a sample or drive timer is still running SHALL be ignored.
REQ-031 dq_oe SHALL only be asserted in PRES_LOW and TX drive windows; never combinationally from dq_in.
REQ-032 Timer widths SHALL hold the largest parameter without overflow (minimum 16 bits for defaults).

Reset
REQ-033 On reset low: state IDLE, dq_oe=0, rx_data=8'h00, rx_valid=0, tx_done=0, counters and shift registers 0, synchroniser flops 1.
REQ-034 Release of reset SHALL not by itself produce presence; a bus reset pulse is required.

Verification
REQ-035 Line low 45000 cycles then released -> dq_oe rises 3000(+2 sync) cycles after release, stays high 12000 cycles.
REQ-036 After presence, master writes 0x3C (slots, 60-cycle low for 1, 6000-cycle low for 0) -> rx_data=0x3C, one rx_valid pulse; second byte 0xA5 -> second pulse, rx_data=0xA5.
REQ-037 After presence, master writes 0xBE with tx_data=0xAA, then 8 read slots -> sampled bits 0,1,0,1,0,1,0,1, dq_oe low for bit1 slots, tx_done pulse once, no rx_valid for 0xBE.
REQ-038 Master issues a 45000-cycle low mid-byte (after 3 bits of RX or TX) -> no rx_valid/tx_done, dq_oe=0, new presence pulse follows.
REQ-039 Line low 39999 cycles then released -> no presence; state unchanged.
REQ-040 Assert reset during PRES_LOW -> dq_oe=0 immediately, outputs at reset values, no presence until next bus reset.
